// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-frame controller:
// FSM state encoding, parity mode codes and the default minimum divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MIN_DIV_DEF = 15;

  // ones_odd is the XOR of payload and received parity bit; mode 11 behaves as none
  function automatic logic parity_error(input logic [1:0] mode, input logic ones_odd);
    logic err;
    case (mode)
      PAR_EVEN: err = ones_odd;
      PAR_ODD:  err = ~ones_odd;
      default:  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input plus one delay flop for
// falling-edge detection; every flop resets to the idle-high line level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic meta;
  logic rxd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      meta  <= rxd;
      rxd_s <= meta;
      rxd_d <= rxd_s;
    end
  end

  assign fall = rxd_d & ~rxd_s;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive-frame controller: mid-bit start validation, LSB-first data,
// optional parity, one or two stop bits, runtime clk-per-bit divisor.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int BAUD_W    = 20,
  parameter int MIN_DIV   = MIN_DIV_DEF,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic                 rx_en,
  input  logic [BAUD_W-1:0]    baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_two,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 baud_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     bit_cnt
);

  state_t               state;
  state_t               state_nx;
  logic                 rxd_s;
  logic                 fall;
  logic [BAUD_W-1:0]    cyc_cnt;
  logic [BAUD_W-1:0]    div_sh;
  logic [1:0]           mode_sh;
  logic                 two_sh;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 stop_idx;
  logic                 cfg_ok;
  logic                 start_ok;
  logic                 half_hit;
  logic                 full_hit;
  logic                 par_on;
  logic                 last_data;
  logic                 last_stop;
  logic                 abort;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  assign cfg_ok    = (baud_div >= BAUD_W'(MIN_DIV));
  assign start_ok  = sel & rx_en & cfg_ok & fall;
  assign half_hit  = (cyc_cnt == (div_sh >> 1) - BAUD_W'(1));
  assign full_hit  = (cyc_cnt == div_sh - BAUD_W'(1));
  assign par_on    = (mode_sh == PAR_EVEN) || (mode_sh == PAR_ODD);
  assign last_data = (bit_cnt == CNT_W'(DATA_BITS));
  assign last_stop = ~two_sh | stop_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Deselect or disable in any active state abandons the frame
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_nx = START; else state_nx = IDLE;
        START:   if (half_hit) state_nx = rxd_s ? IDLE : DATA; else state_nx = START;
        DATA:    if (full_hit && last_data) state_nx = par_on ? PARITY : STOP; else state_nx = DATA;
        PARITY:  if (full_hit) state_nx = STOP; else state_nx = PARITY;
        STOP:    if (full_hit && last_stop) state_nx = DONE; else state_nx = STOP;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE: begin
        busy  = 1'b0;
        abort = 1'b0;
      end
      START, DATA, PARITY, STOP, DONE: begin
        busy  = 1'b1;
        abort = ~sel | ~rx_en;
      end
      default: begin
        busy  = 1'b0;
        abort = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      div_sh     <= '0;
      mode_sh    <= PAR_NONE;
      two_sh     <= 1'b0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      stop_idx   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      baud_err   <= 1'b0;
    end else begin
      baud_err   <= sel & ~cfg_ok;
      data_valid <= 1'b0;
      if (abort) begin
        cyc_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (start_ok) begin
            // Configuration is frozen for the whole frame from here on
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            div_sh   <= baud_div;
            mode_sh  <= parity_mode;
            two_sh   <= stop_two;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            stop_idx <= 1'b0;
          end
          START: if (half_hit) begin
            cyc_cnt <= '0;
            if (!rxd_s) bit_cnt <= CNT_W'(1);
          end else begin
            cyc_cnt <= cyc_cnt + BAUD_W'(1);
          end
          DATA: if (full_hit) begin
            cyc_cnt <= '0;
            bit_cnt <= bit_cnt + CNT_W'(1);
            shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
          end else begin
            cyc_cnt <= cyc_cnt + BAUD_W'(1);
          end
          PARITY: if (full_hit) begin
            cyc_cnt <= '0;
            bit_cnt <= bit_cnt + CNT_W'(1);
            perr    <= parity_error(mode_sh, (^shreg) ^ rxd_s);
          end else begin
            cyc_cnt <= cyc_cnt + BAUD_W'(1);
          end
          STOP: if (full_hit) begin
            cyc_cnt  <= '0;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            stop_idx <= 1'b1;
            if (!rxd_s) ferr <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + BAUD_W'(1);
          end
          DONE: begin
            data_out   <= shreg;
            parity_err <= perr;
            frame_err  <= ferr;
            data_valid <= 1'b1;
          end
          default: begin
            cyc_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Parametrised UART receive-frame controller and the successor to the fixed 10/8-bit receive bit counter. It runs on one system clock and times bits from a runtime clk-per-bit divisor, so no separate baud clock is needed. Data width is set by parameter; parity and stop-bit count are set at runtime. It validates the start bit at mid-bit, samples LSB first, and reports data, parity and framing status to the UART register block.

Parameters:
DATA_BITS, 8, payload bits per frame; legal range 5..9
BAUD_W, 20, width of the baud_div input
MIN_DIV, 15, smallest legal baud_div (clk cycles per bit)
CNT_W, 4, width of bit_cnt; must hold DATA_BITS+4

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
sel  in  1  block select; 0 = standby
rx_en  in  1  receive enable
baud_div  in  BAUD_W  clk cycles per bit
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
stop_two  in  1  1 = two stop bits expected
rxd  in  1  asynchronous serial input, idle high
data_out  out  DATA_BITS  last received payload
data_valid  out  1  one-cycle pulse, frame complete
parity_err  out  1  parity status of last frame; valid with data_valid
frame_err  out  1  stop-bit status of last frame; valid with data_valid
baud_err  out  1  registered flag: sel=1 and baud_div<MIN_DIV
busy  out  1  high in any state other than IDLE
bit_cnt  out  CNT_W  bits sampled in the current/last frame; the start bit counts as 1

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high, and has priority over everything else.
- Reset values: all outputs 0, state IDLE, synchronizer flops 1.
- Synchronizer: rxd passes through 2 flops to give rxd_s; a 1-flop delayed copy gives rxd_d. fall = rxd_d & ~rxd_s.
- cfg_ok = (baud_div >= MIN_DIV). baud_err <= sel & ~cfg_ok every cycle.
- IDLE:
  - On sel & rx_en & cfg_ok & fall: go to START, clear cyc_cnt, clear bit_cnt.
  - On the same transition, latch baud_div, parity_mode and stop_two into shadow registers. Config changes mid-frame are ignored.
- Bit timing: cyc_cnt increments every clk in START, DATA, PARITY and STOP.
- START: when cyc_cnt == (div_sh>>1)-1, sample rxd_s.
  - rxd_s=0: go to DATA, bit_cnt=1, cyc_cnt=0.
  - rxd_s=1: false start; return to IDLE with no outputs changed.
- DATA/PARITY/STOP sample point: cyc_cnt == div_sh-1. At each sample, clear cyc_cnt and increment bit_cnt.
- DATA: shift rxd_s in LSB first. After DATA_BITS samples, go to PARITY if the latched mode is even or odd, otherwise go to STOP.
- PARITY: compute p = XOR(payload, sampled bit). For even, perr = p; for odd, perr = ~p. Then go to STOP.
- STOP:
  - Any stop sample equal to 0 sets ferr.
  - If stop_two is latched, take a second sample; after the last sample go to DONE.
- DONE (one cycle):
  - data_out <= shift register; parity_err <= perr; frame_err <= ferr; data_valid=1; return to IDLE.
  - data_valid still fires when an error is set.
- Output hold: data_out, parity_err, frame_err and bit_cnt hold until the next DONE or next start, except bit_cnt, which clears at start detect.
- Abort: if sel=0, rx_en=0 or rst in any non-IDLE state, go to IDLE on the next edge.
  - No data_valid is produced; bit_cnt is cleared.
  - data_out, parity_err and frame_err keep their previous values, except on rst, which clears them.
- Re-arm: a new frame requires a fresh falling edge, so a line stuck low after a framing error does not retrigger.
- Latency: data_valid rises div_sh/2 + (N-1)*div_sh + 1 cycles after start-bit detect, where N is the total bits in the frame. The rxd-to-detect delay is 3 clks.
- busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg holds:
  - state encoding IDLE/START/DATA/PARITY/STOP/DONE
  - parity_mode constants PAR_NONE/PAR_EVEN/PAR_ODD
  - default MIN_DIV
- One sub-module, uart_rx_sync: 2-flop synchronizer plus delay flop and fall output, reset to 1.
- FSM, cycle counter, shift register and checks stay in uart_rx_frame_ctrl.

Test Plan:
- 8N1, baud_div=16, send 0xA5 with stop=1 -> data_valid one cycle, data_out=0xA5, parity_err=0, frame_err=0, bit_cnt=10.
- 8E1, baud_div=20, send 0x03 with parity bit 1 -> data_out=0x03, parity_err=1; repeat with parity bit 0 -> parity_err=0, bit_cnt=11.
- DATA_BITS=7, odd parity, stop_two=1, send 0x55 with parity 1, stop1=1, stop2=0 -> frame_err=1, parity_err=0, bit_cnt=11, data_valid still pulses.
- baud_div=16, rxd low for 5 clks then high -> false start; no data_valid, busy returns to 0 within 9 clks; a following valid 0x3C is received correctly.
- baud_div=10 with sel=1 -> baud_err=1 next cycle; a full frame on rxd gives busy=0 and no data_valid. Setting baud_div=15 clears baud_err and reception works.
- Mid-data abort:
  - rx_en dropped during data bit 4 -> IDLE next clk, bit_cnt=0, no data_valid, data_out unchanged.
  - rst asserted mid-frame -> all outputs 0 on the next edge.
